// File: rtl/bringup_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bringup_uart_tx_pkg
// Description : Shared types and constants for the bringup UART transmitter:
//               transmit FSM state encoding, scanner start byte, default
//               bit period and the parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bringup_uart_tx_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    // First byte of every scanner record
    localparam logic [7:0] c_SCANNER_START_BYTE = 8'hf0;

    // 12 MHz system clock / 115200 baud
    localparam int c_DEFAULT_CLKS_PER_BIT = 104;

    // Even parity bit: makes the total count of ones in data+parity even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage : bringup_uart_tx_pkg
`default_nettype wire

// File: rtl/bringup_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bringup_byte_fifo
// Description : Byte FIFO with synchronous-read storage. The head byte is
//               prefetched into an output register so dout is valid whenever
//               the FIFO is not empty. Push is ignored when full, pop is
//               ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module bringup_byte_fifo #(
    parameter int DEPTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int               c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]    c_ONE_CNT  = (c_AW + 1)'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [7:0]      r_dout;
    logic [c_AW-1:0] w_rd_next;
    logic            w_push;
    logic            w_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_CNT);
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign dout      = r_dout;

    // Storage write; contents need no reset since the count qualifies them
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and head prefetch register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The head after a pop is either the next stored entry or, when
            // the last entry leaves, the byte being pushed right now.
            if (w_pop) begin
                if (r_count == c_ONE_CNT) begin
                    r_dout <= din;
                end else begin
                    r_dout <= r_mem[w_rd_next];
                end
            end else if (w_push && empty) begin
                r_dout <= din;
            end
        end
    end

endmodule : bringup_byte_fifo
`default_nettype wire

// File: rtl/bringup_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : bringup_uart_tx
// Description : Buffers scanner bytes in a FIFO and serialises them LSB-first
//               as UART frames (8N1, or 8E1 when BRINGUP_UART_TX_PARITY_EN is
//               defined). hold_o backpressures the scanner when the FIFO is
//               full. Frames run back-to-back while bytes are queued.
// Config      : `define BRINGUP_UART_TX_PARITY_EN for an even parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bringup_uart_tx
    import bringup_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_i,
    input  logic [7:0] data_i,
    output logic       hold_o,
    output logic       tx_o,
    output logic       busy_o
);
    localparam int              c_TW         = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_TIMER_LOAD = c_TW'(CLKS_PER_BIT - 1);

    uart_state_e     r_state;
    uart_state_e     w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            w_pop;
    logic            w_timer_done;
    logic [7:0]      w_fifo_dout;
    logic            w_fifo_empty;
    logic            w_fifo_full;
`ifdef BRINGUP_UART_TX_PARITY_EN
    logic            r_parity;
    logic            w_parity_nxt;
`endif

    bringup_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (write_i),
        .din   (data_i),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign w_timer_done = (r_timer == '0);
    assign hold_o       = w_fifo_full;
    assign tx_o         = r_tx;
    assign busy_o       = (r_state != UART_IDLE) || !w_fifo_empty;

    // Next-state, bit timing and next serial level; tx is registered from these
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
`ifdef BRINGUP_UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        if (r_state != UART_IDLE) begin
            w_timer_nxt = w_timer_done ? c_TIMER_LOAD : (r_timer - 1'b1);
        end
        case (r_state)
            UART_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_timer_nxt = c_TIMER_LOAD;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = UART_START;
`ifdef BRINGUP_UART_TX_PARITY_EN
                    w_parity_nxt = even_parity(w_fifo_dout);
`endif
                end
            end
            UART_START: begin
                if (w_timer_done) begin
                    w_state_nxt   = UART_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            UART_DATA: begin
                if (w_timer_done) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef BRINGUP_UART_TX_PARITY_EN
                        w_state_nxt = UART_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = UART_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef BRINGUP_UART_TX_PARITY_EN
            UART_PARITY: begin
                if (w_timer_done) begin
                    w_state_nxt = UART_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            UART_STOP: begin
                if (w_timer_done) begin
                    // Chain straight into the next start bit when data waits
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = UART_START;
`ifdef BRINGUP_UART_TX_PARITY_EN
                        w_parity_nxt = even_parity(w_fifo_dout);
`endif
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = UART_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = UART_IDLE;
            end
        endcase
    end

    // State, timer, shift register and serial output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= UART_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

`ifdef BRINGUP_UART_TX_PARITY_EN
    // Parity of the byte currently being sent, captured when it is popped
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

endmodule : bringup_uart_tx
`default_nettype wire

// File: tb/tb_bringup_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bringup_uart_tx
// Description : Self-checking bench for bringup_uart_tx. A byte-queue model
//               predicts the tx_o waveform, busy_o and hold_o every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bringup_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef BRINGUP_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       write_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       hold_o;
    logic       tx_o;
    logic       busy_o;

    always #5 clock = ~clock;

    bringup_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .write_i (write_i),
        .data_i  (data_i),
        .hold_o  (hold_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         edge_n = 0;
    logic [7:0] m_bytes[$];
    int         m_tags[$];
    logic       wave[$];
    logic       accepted;

    // Expected line levels for one frame, every bit repeated CPB times
    task automatic load_frame(input logic [7:0] b);
        int bits[$];
        int ones;
        int v;
        ones = 0;
        v    = int'(b);
        bits.push_back(0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(v % 2);
            ones += v % 2;
            v = v / 2;
        end
`ifdef BRINGUP_UART_TX_PARITY_EN
        bits.push_back(ones % 2);
`endif
        bits.push_back(1);
        foreach (bits[i]) begin
            for (int r = 0; r < CPB; r++) begin
                wave.push_back(bits[i] != 0);
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
        end
    endtask

    // One clock: update model for the edge, then compare outputs #1 later
    task automatic step();
        logic       w_in;
        logic       rst_in;
        logic       hold_before;
        logic [7:0] d_in;
        logic       active;
        logic       exp_tx;
        logic       exp_busy;
        logic       exp_hold;
        w_in        = write_i;
        d_in        = data_i;
        rst_in      = reset;
        hold_before = hold_o;
        @(posedge clock);
        edge_n++;
        accepted = w_in && !hold_before && !rst_in;
        if (rst_in) begin
            m_bytes.delete();
            m_tags.delete();
            wave.delete();
        end else begin
            if (w_in && m_bytes.size() < DEPTH) begin
                m_bytes.push_back(d_in);
                m_tags.push_back(edge_n);
            end
            if (wave.size() == 0 && m_bytes.size() > 0 && m_tags[0] < edge_n) begin
                load_frame(m_bytes.pop_front());
                void'(m_tags.pop_front());
            end
        end
        active   = (wave.size() > 0);
        exp_tx   = active ? wave.pop_front() : 1'b1;
        exp_busy = active || (m_bytes.size() != 0);
        exp_hold = (m_bytes.size() == DEPTH);
        #1;
        check_bit("tx_o", tx_o, exp_tx);
        check_bit("busy_o", busy_o, exp_busy);
        check_bit("hold_o", hold_o, exp_hold);
    endtask

    initial begin
        logic [7:0] stim[8];
        int         k;

        // Reset state
        reset = 1'b1;
        for (int c = 0; c < 3; c++) step();
        reset = 1'b0;

        // Idle line
        for (int c = 0; c < 50; c++) step();

        // Single byte frame
        write_i = 1'b1; data_i = 8'hA5;
        step();
        write_i = 1'b0;
        for (int c = 0; c < FRAME_CYC + 5; c++) step();

        // Back-to-back frames
        write_i = 1'b1; data_i = 8'hf0; step();
        data_i = 8'h01; step();
        data_i = 8'h02; step();
        write_i = 1'b0;
        for (int c = 0; c < 3 * FRAME_CYC + 5; c++) step();

        // Backpressure with write_i held high
        for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
        k = 0;
        write_i = 1'b1; data_i = stim[0];
        for (int c = 0; c < 600 && k < 8; c++) begin
            step();
            if (accepted) begin
                k++;
                if (k < 8) data_i = stim[k];
                else write_i = 1'b0;
            end
        end
        write_i = 1'b0;
        n_cmp++;
        assert (k === 8) else begin
            n_fail++;
            $error("FAIL accept_count: observed %0d expected %0d", k, 8);
        end
        for (int c = 0; c < 6 * FRAME_CYC; c++) step();

        // Reset in the middle of data bit 3, with a second byte queued
        write_i = 1'b1; data_i = 8'hFF; step();
        data_i = 8'h55; step();
        write_i = 1'b0;
        for (int c = 0; c < 17; c++) step();
        reset = 1'b1; step();
        reset = 1'b0;
        for (int c = 0; c < FRAME_CYC + 10; c++) step();

`ifdef BRINGUP_UART_TX_PARITY_EN
        // Parity bit: 8'h07 has three ones, 8'h03 has two
        write_i = 1'b1; data_i = 8'h07; step();
        write_i = 1'b0;
        for (int c = 0; c < 37; c++) step();
        check_bit("parity_07", tx_o, 1'b1);
        for (int c = 0; c < FRAME_CYC; c++) step();
        write_i = 1'b1; data_i = 8'h03; step();
        write_i = 1'b0;
        for (int c = 0; c < 37; c++) step();
        check_bit("parity_03", tx_o, 1'b0);
        for (int c = 0; c < FRAME_CYC; c++) step();
`endif

        // Random traffic with occasional holds
        for (int c = 0; c < 600; c++) begin
            if (!write_i && $urandom_range(0, 2) == 0) begin
                write_i = 1'b1;
                data_i  = 8'($urandom);
            end
            step();
            if (accepted) write_i = 1'b0;
        end
        write_i = 1'b0;
        for (int c = 0; c < (DEPTH + 2) * FRAME_CYC; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bringup_uart_tx
`default_nettype wire
